// File: rtl/uart_rx.sv
// 8N1 UART receive front-end: synchronizes and oversamples rx, majority-votes
// each mid-bit sample, and emits one-cycle rx_ready / frame_err strobes.
module uart_rx #(
    parameter int unsigned CLK_FREQ    = 12000000,
    parameter int unsigned UART_FREQ   = 115200,
    parameter int unsigned BIT_CYCLES  = (CLK_FREQ + UART_FREQ / 2) / UART_FREQ,
    parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       dbg_rx_enable
);

    localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       data_nxt;
    logic             ready_nxt;
    logic             ferr_nxt;
    logic [1:0]       rx_sync;
    logic [2:0]       rx_hist;
    logic             rx_s;
    logic             vote;

    assign rx_s = rx_sync[1];
    // rx_hist[0] is the previous rx_s, so it doubles as the edge-detect history
    assign vote = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) | (rx_hist[1] & rx_hist[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            rx_sync       <= 2'b11;
            rx_hist       <= 3'b111;
            rx_data       <= '0;
            rx_ready      <= 1'b0;
            frame_err     <= 1'b0;
            dbg_rx_enable <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            shreg         <= shreg_nxt;
            rx_sync       <= {rx_sync[0], rx};
            rx_hist       <= {rx_hist[1:0], rx_s};
            rx_data       <= data_nxt;
            rx_ready      <= ready_nxt;
            frame_err     <= ferr_nxt;
            dbg_rx_enable <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = rx_data;
        ready_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rx_hist[0] && !rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!vote) begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = vote;
                    if (idx == 3'd7) state_nxt = S_STOP;
                    else             idx_nxt   = idx + 3'd1;
                end
            end
            S_STOP: begin
                // Decide mid stop bit so a back-to-back start edge is still seen
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (vote) begin
                        data_nxt  = shreg;
                        ready_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_nxt = '0;
                if (rx_s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a negedge
// monitor pops and compares on every rx_ready pulse.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       dbg_rx_enable;

    uart_rx dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .frame_err     (frame_err),
        .dbg_rx_enable (dbg_rx_enable)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         fall_cyc = 0;
    int         ferr_seen = 0;
    int         ferr_exp  = 0;
    bit         mon_en   = 0;
    bit         lat_en   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_data = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected bytes on rx_ready, counts frame errors
    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_ready || frame_err)
                check("pulse_exclusive", 32'(rx_ready & frame_err), 32'd0);
            if (rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_ready", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                    last_data = e;
                end
                if (lat_en) begin
                    int d;
                    d = cyc - fall_cyc;
                    checks++;
                    if (d < 990 || d > 994) begin
                        failures++;
                        $display("FAIL latency actual=%0d required=990..994", d);
                    end
                    lat_en = 0;
                end
            end
            if (frame_err) ferr_seen++;
        end
    end

    // Drives start, 8 data bits LSB first, and a stop bit of stop_len cycles
    task automatic send_frame(input logic [7:0] b, input int n, input logic stop_val,
                              input int stop_len, input int glitch_at, input int rst_at);
        logic [9:0] bits;
        int t;
        int len;
        bits = {stop_val, b, 1'b0};
        t = 0;
        for (int i = 0; i < 10; i++) begin
            len = (i == 9) ? stop_len : n;
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                if (rst_at >= 0 && t == rst_at)
                    check("dbg_before_reset", 32'(dbg_rx_enable), 32'd1);
                if (rst_at >= 0 && t == rst_at + 1)
                    check("dbg_after_reset", 32'(dbg_rx_enable), 32'd0);
                if (t == 0) fall_cyc = cyc;
                rx    = bits[i] ^ (t == glitch_at);
                reset = (t == rst_at);
                t++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rx    = 1'b1;
            reset = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        idle(300);
        check(name, 32'(exp_q.size()), 32'd0);
        check("dbg_idle", 32'(dbg_rx_enable), 32'd0);
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_dbg", 32'(dbg_rx_enable), 32'd0);
        mon_en = 1;
        idle(20);

        // 0x55 with latency measurement
        exp_q.push_back(8'h55);
        lat_en = 1;
        send_frame(8'h55, 104, 1'b1, 104, -1, -1);
        drain("frame_55_drained");
        check("no_ferr_after_55", 32'(ferr_seen), 32'd0);

        // 20-clock low glitch on idle line
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(200);
        check("glitch_dbg_idle", 32'(dbg_rx_enable), 32'd0);
        check("glitch_rx_data_held", 32'(rx_data), 32'h55);
        check("glitch_no_ferr", 32'(ferr_seen), 32'd0);

        // 0x00 with 3-bit-time break, then 0xC3
        ferr_exp++;
        send_frame(8'h00, 104, 1'b0, 312, -1, -1);
        drain("break_drained");
        check("break_ferr_count", 32'(ferr_seen), 32'(ferr_exp));
        check("break_rx_data_held", 32'(rx_data), 32'h55);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 104, 1'b1, 104, -1, -1);
        drain("frame_c3_drained");

        // Back-to-back at +3% baud, no idle between frames
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'hFF);
        send_frame(8'hA3, 101, 1'b1, 101, -1, -1);
        send_frame(8'h3A, 101, 1'b1, 101, -1, -1);
        send_frame(8'hFF, 101, 1'b1, 101, -1, -1);
        drain("b2b_drained");

        // 0xF0 with a 1-clock inverted pulse at the bit-4 sample point
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 104, 1'b1, 104, 570, -1);
        drain("vote_drained");

        // Reset during bit 3; remaining bits high so no false start follows
        send_frame(8'hF8, 104, 1'b1, 104, -1, 4 * 104 + 52);
        idle(300);
        check("reset_frame_no_data", 32'(rx_data), 32'h00);
        check("reset_frame_queue", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 104, 1'b1, 104, -1, -1);
        drain("frame_81_drained");
        check("final_rx_data", 32'(rx_data), 32'h81);
        check("final_ferr_count", 32'(ferr_seen), 32'(ferr_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
